// File: rtl/dict_pkg.sv
// Shared constants and types for the boot-time dictionary loader.
// Field sizes, entry counts, image base address and the loader state encoding.
package dict_pkg;

  // Key widths set the number of entries per dictionary (2^key).
  localparam int unsigned FIELD1_KEY_W = 3;
  localparam int unsigned FIELD2_KEY_W = 5;
  localparam int unsigned FIELD3_KEY_W = 8;

  localparam int unsigned FIELD1_VAL_W = 7;
  localparam int unsigned FIELD2_VAL_W = 10;
  localparam int unsigned FIELD3_VAL_W = 15;

  localparam int unsigned FIELD1_N = 1 << FIELD1_KEY_W;
  localparam int unsigned FIELD2_N = 1 << FIELD2_KEY_W;
  localparam int unsigned FIELD3_N = 1 << FIELD3_KEY_W;

  localparam int unsigned TOTAL_ENTRIES = FIELD1_N + FIELD2_N + FIELD3_N;

  localparam logic [31:0] DICT_BASE_ADDR_DEFAULT = 32'h0001_0000;

  // First global entry index belonging to fields 2 and 3.
  localparam int unsigned FIELD2_FIRST = FIELD1_N;
  localparam int unsigned FIELD3_FIRST = FIELD1_N + FIELD2_N;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWrite,
    StDone
  } dict_state_e;

endpackage

// File: rtl/dict_loader.sv
// Boot-time dictionary loader: walks the dictionary image in memory, one word per
// entry, and pulses the matching dictN write port for each entry.
// Optional build macro DICT_LOADER_CHECKSUM_EN fetches one trailing checksum word and
// reports a mismatch on load_error.
module dict_loader
  import dict_pkg::*;
#(
  parameter int unsigned FIELD1_VAL_WIDTH = FIELD1_VAL_W,
  parameter int unsigned FIELD2_VAL_WIDTH = FIELD2_VAL_W,
  parameter int unsigned FIELD3_VAL_WIDTH = FIELD3_VAL_W,
  parameter int unsigned FIELD1_ENTRIES   = FIELD1_N,
  parameter int unsigned FIELD2_ENTRIES   = FIELD2_N,
  parameter int unsigned FIELD3_ENTRIES   = FIELD3_N,
  parameter logic [31:0] DICT_BASE_ADDR   = DICT_BASE_ADDR_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [31:0]                 mem_req_addr,
  input  logic [31:0]                 mem_req_rdata,
  output logic                        dict1_write_enable,
  output logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
  output logic                        dict2_write_enable,
  output logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
  output logic                        dict3_write_enable,
  output logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val,
  output logic                        busy,
  output logic                        load_done
`ifdef DICT_LOADER_CHECKSUM_EN
  ,
  output logic                        load_error
`endif
);

  localparam int unsigned TOTAL = FIELD1_ENTRIES + FIELD2_ENTRIES + FIELD3_ENTRIES;
  // Counter must reach TOTAL (checksum index / post-load value).
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] CHK_IDX  = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] F2_FIRST = CNT_W'(FIELD1_ENTRIES);
  localparam logic [CNT_W-1:0] F3_FIRST = CNT_W'(FIELD1_ENTRIES + FIELD2_ENTRIES);

`ifdef DICT_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  dict_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_chk;

  // The request in flight is the trailing checksum word rather than an entry.
  assign is_chk = CHK_EN && (cnt_q == CHK_IDX);

  // Loader FSM with counter, address generation and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= StIdle;
      cnt_q              <= '0;
      mem_req_valid      <= 1'b0;
      mem_req_addr       <= DICT_BASE_ADDR;
      dict1_write_enable <= 1'b0;
      dict1_write_val    <= '0;
      dict2_write_enable <= 1'b0;
      dict2_write_val    <= '0;
      dict3_write_enable <= 1'b0;
      dict3_write_val    <= '0;
      busy               <= 1'b0;
      load_done          <= 1'b0;
    end else begin
      dict1_write_enable <= 1'b0;
      dict2_write_enable <= 1'b0;
      dict3_write_enable <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q       <= StReq;
            mem_req_valid <= 1'b1;
            busy          <= 1'b1;
          end
        end
        StReq: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (is_chk) begin
              state_q   <= StDone;
              busy      <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state_q <= StWrite;
              if (cnt_q < F2_FIRST) begin
                dict1_write_enable <= 1'b1;
                dict1_write_val    <= mem_req_rdata[FIELD1_VAL_WIDTH-1:0];
              end else if (cnt_q < F3_FIRST) begin
                dict2_write_enable <= 1'b1;
                dict2_write_val    <= mem_req_rdata[FIELD2_VAL_WIDTH-1:0];
              end else begin
                dict3_write_enable <= 1'b1;
                dict3_write_val    <= mem_req_rdata[FIELD3_VAL_WIDTH-1:0];
              end
            end
          end
        end
        StWrite: begin
          cnt_q        <= cnt_q + 1'b1;
          mem_req_addr <= mem_req_addr + 32'd4;
          if (cnt_q == LAST_IDX && !CHK_EN) begin
            state_q   <= StDone;
            busy      <= 1'b0;
            load_done <= 1'b1;
          end else begin
            state_q       <= StReq;
            mem_req_valid <= 1'b1;
          end
        end
        StDone: begin
          // Terminal until reset.
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef DICT_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;

  // Accumulate every captured image word; judge the trailing checksum word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q      <= '0;
      load_error <= 1'b0;
    end else if (state_q == StReq && mem_req_ready) begin
      if (is_chk) begin
        load_error <= (mem_req_rdata != sum_q);
      end else begin
        sum_q <= sum_q + mem_req_rdata;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dict_loader.sv
// Self-checking bench for dict_loader: a memory responder with per-entry wait states
// and a monitor comparing every write pulse against the image and field ranges.
// Build with DICT_LOADER_CHECKSUM_EN to exercise the checksum word.
module tb_dict_loader;

  localparam int unsigned N1    = 8;
  localparam int unsigned N2    = 32;
  localparam int unsigned N3    = 256;
  localparam int unsigned TOTAL = N1 + N2 + N3;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          BUDGET = 5000;
`ifdef DICT_LOADER_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_rdata;
  logic        we1, we2, we3;
  logic [6:0]  val1;
  logic [9:0]  val2;
  logic [14:0] val3;
  logic        busy;
  logic        load_done;
  logic        load_error;

  dict_loader dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_addr       (mem_req_addr),
    .mem_req_rdata      (mem_req_rdata),
    .dict1_write_enable (we1),
    .dict1_write_val    (val1),
    .dict2_write_enable (we2),
    .dict2_write_val    (val2),
    .dict3_write_enable (we3),
    .dict3_write_val    (val3),
    .busy               (busy),
`ifdef DICT_LOADER_CHECKSUM_EN
    .load_done          (load_done),
    .load_error         (load_error)
`else
    .load_done          (load_done)
`endif
  );

`ifndef DICT_LOADER_CHECKSUM_EN
  assign load_error = 1'b0;
`endif

  int          checks;
  int          errors;
  logic [31:0] img    [0:TOTAL];
  int          dly    [0:TOTAL];
  logic [31:0] got_val[0:TOTAL-1];

  // Monitor-side model state.
  int          wr_count;
  int          n1, n2, n3;
  int          vcycles;
  bit          prev_valid, prev_we;
  logic [6:0]  last1;
  logic [9:0]  last2;
  logic [14:0] last3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: answers dly[idx] cycles after valid rises; random ready noise when idle.
  initial begin
    int          wt;
    int          idx;
    int          d;
    logic [31:0] noise;
    mem_req_ready = 1'b0;
    mem_req_rdata = '0;
    wt            = 0;
    forever begin
      @(negedge clk);
      if (reset || !mem_req_valid) begin
        wt            = 0;
        noise         = $urandom;
        mem_req_ready = noise[0] & ~reset;
        mem_req_rdata = $urandom;
      end else begin
        idx = int'((mem_req_addr - BASE) >> 2);
        d   = (idx >= 0 && idx <= int'(TOTAL)) ? dly[idx] : 0;
        if (wt >= d) begin
          mem_req_ready = 1'b1;
          mem_req_rdata = (idx >= 0 && idx <= int'(TOTAL)) ? img[idx] : $urandom;
        end else begin
          mem_req_ready = 1'b0;
          mem_req_rdata = $urandom;
          wt++;
        end
      end
    end
  end

  // Monitor: address/wait-state rules per request and expected field/value per pulse.
  initial begin
    int   nwe;
    bit   we_any;
    logic [2:0] exp_en;
    wr_count = 0; n1 = 0; n2 = 0; n3 = 0; vcycles = 0;
    prev_valid = 0; prev_we = 0; last1 = '0; last2 = '0; last3 = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        wr_count = 0; n1 = 0; n2 = 0; n3 = 0; vcycles = 0;
        prev_valid = 0; prev_we = 0; last1 = '0; last2 = '0; last3 = '0;
      end else begin
        we_any = we1 | we2 | we3;
        nwe    = int'(we1) + int'(we2) + int'(we3);
        if (mem_req_valid) begin
          check("req_addr", mem_req_addr, BASE + 32'(4 * wr_count));
          vcycles++;
        end
        if (prev_valid && !mem_req_valid) begin
          check("req_wait_cycles", 32'(vcycles), 32'(dly[wr_count] + 1));
          vcycles = 0;
          if (wr_count < int'(TOTAL)) check("pulse_after_ready", 32'(we_any), 32'd1);
        end
        if (we_any) begin
          check("one_enable", 32'(nwe), 32'd1);
          check("no_back_to_back", 32'(prev_we), 32'd0);
          check("pulse_after_req", 32'(prev_valid), 32'd1);
          if (wr_count >= int'(TOTAL)) begin
            check("extra_pulse", 32'(wr_count), 32'(TOTAL - 1));
          end else begin
            if (wr_count < int'(N1)) begin
              exp_en = 3'b001; last1 = img[wr_count][6:0]; n1++;
            end else if (wr_count < int'(N1 + N2)) begin
              exp_en = 3'b010; last2 = img[wr_count][9:0]; n2++;
            end else begin
              exp_en = 3'b100; last3 = img[wr_count][14:0]; n3++;
            end
            check("enables", 32'({we3, we2, we1}), 32'(exp_en));
            check("val1", 32'(val1), 32'(last1));
            check("val2", 32'(val2), 32'(last2));
            check("val3", 32'(val3), 32'(last3));
            got_val[wr_count] = (exp_en == 3'b001) ? 32'(val1) :
                                (exp_en == 3'b010) ? 32'(val2) : 32'(val3);
            wr_count++;
          end
        end
        prev_valid = mem_req_valid;
        prev_we    = we_any;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); #1 reset = 1'b1;
    @(negedge clk); #1 reset = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (!load_done && t < BUDGET) begin
      @(negedge clk); #1;
      t++;
    end
    check(tag, 32'(load_done), 32'd1);
  endtask

  task automatic set_checksum(input logic [31:0] delta);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < int'(TOTAL); i++) s = s + img[i];
    img[TOTAL] = s + delta;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(mem_req_valid), 32'd0);
    check({tag, "_addr"}, mem_req_addr, BASE);
    check({tag, "_we"}, 32'({we3, we2, we1}), 32'd0);
    check({tag, "_vals"}, 32'({val3, val2, val1}), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(load_done), 32'd0);
    check({tag, "_err"}, 32'(load_error), 32'd0);
  endtask

  initial begin
    int t;
    bit injected;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    start  = 1'b0;
    for (int i = 0; i <= int'(TOTAL); i++) begin
      dly[i] = 0;
      img[i] = 32'hA500_0000 | 32'(i);
    end
    set_checksum(32'd0);

    // Reset state, then idle with ready noise must stay quiet.
    repeat (2) @(negedge clk);
    #1 check_idle_outputs("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);
    #1 check_idle_outputs("idle");

    // Zero-wait load with a stray start at entry 40; latency counted inclusively.
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    t = 1;
    injected = 0;
    while (!load_done && t < BUDGET) begin
      if (!injected && wr_count == 40) begin
        start = 1'b1;
        injected = 1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk); #1;
      t++;
    end
    start = 1'b0;
    check("done_latency", 32'(t + 1), 32'(2 + 2 * TOTAL + CHK));
    check("count_f1", 32'(n1), 32'(N1));
    check("count_f2", 32'(n2), 32'(N2));
    check("count_f3", 32'(n3), 32'(N3));
    check("first_f2_val", got_val[N1], 32'h008);
    check("last_f3_val", got_val[TOTAL-1], 32'h0127);
    check("done_busy", 32'(busy), 32'd0);
    check("chk_ok_err", 32'(load_error), 32'd0);

    // Start in DONE is ignored.
    pulse_start();
    repeat (20) @(negedge clk);
    #1;
    check("post_done_count", 32'(wr_count), 32'(TOTAL));
    check("post_done_flag", 32'(load_done), 32'd1);
    check("post_done_busy", 32'(busy), 32'd0);
    check("post_done_valid", 32'(mem_req_valid), 32'd0);

    // Random image, random wait states, masked entry 0, reset at entry 100.
    do_reset();
    for (int i = 0; i <= int'(TOTAL); i++) begin
      img[i] = $urandom;
      dly[i] = int'($urandom_range(0, 3));
    end
    img[0] = 32'hFFFF_FF85;
    dly[5] = 3;
    set_checksum(32'd0);
    pulse_start();
    t = 0;
    while (wr_count < 100 && t < BUDGET) begin
      @(negedge clk); #1;
      t++;
    end
    check("reach_entry_100", 32'(wr_count), 32'd100);
    check("mask_entry0", got_val[0], 32'h05);
    reset = 1'b1;
    #1 check_idle_outputs("midload_reset");
    @(negedge clk); #1 reset = 1'b0;

    // Fresh start after mid-load reset reloads from entry 0.
    for (int i = 0; i <= int'(TOTAL); i++) dly[i] = int'($urandom_range(0, 3));
    pulse_start();
    wait_done("reload_done");
    check("reload_count", 32'(wr_count), 32'(TOTAL));
    check("reload_f3", 32'(n3), 32'(N3));
    check("reload_err", 32'(load_error), 32'd0);

`ifdef DICT_LOADER_CHECKSUM_EN
    // Checksum word off by one: error flagged, load still completes.
    do_reset();
    set_checksum(32'd1);
    pulse_start();
    wait_done("bad_chk_done");
    check("bad_chk_err", 32'(load_error), 32'd1);
    check("bad_chk_count", 32'(wr_count), 32'(TOTAL));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
